block_packer: RTL and testbench

//   Serialises one compressed 32-pixel RGBA block (header + residuals) into a
//   32-bit word stream. Sits directly downstream of the compressor (cpu), taking
//   its types::header_residual_reg and feeding the link/output FIFO via valid/ready.

---
 rtl/block_packer_pkg.sv | 39 +++
 rtl/block_packer_if.sv | 23 ++
 rtl/block_packer_bit_accumulator.sv | 45 ++++
 rtl/block_packer.sv | 116 +++++++++++
 tb/tb_block_packer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/block_packer_pkg.sv
// rtl/block_packer_pkg.sv - shared types for the block packer
// Block geometry, header/residual layout and the width clamp helper.
package block_packer_pkg;
  localparam int NUM_PIXELS = 32;
  localparam int NUM_CH     = 4;
  localparam int WORD_W     = 32;

  typedef logic [3:0] width_t;

  typedef struct packed {
    width_t r_w;
    width_t g_w;
    width_t b_w;
    width_t a_w;
  } widths_t;

  typedef struct packed {
    logic [7:0] r_min;
    logic [7:0] g_min;
    logic [7:0] b_min;
    logic [7:0] a_min;
  } min_values_t;

  typedef struct packed {
    min_values_t min_values;
    widths_t     widths;
  } header_t;

  typedef logic [NUM_PIXELS-1:0][NUM_CH-1:0][7:0] residuals_t;

  typedef struct packed {
    header_t    header;
    residuals_t residuals;
  } header_residual_reg;

  function automatic width_t clamp_width(input width_t w);
    return (w > 4'd8) ? 4'd8 : w;
  endfunction
endpackage

// File: rtl/block_packer_if.sv
// rtl/block_packer_if.sv - block input and word stream handshake bundle
// master drives blocks in and consumes words; slave is the packer side.
interface block_packer_if;
  import block_packer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  header_residual_reg hr_reg;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;
  logic               out_last;

  modport master (
    output in_valid, hr_reg, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, hr_reg, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/block_packer_bit_accumulator.sv
// rtl/block_packer_bit_accumulator.sv - 40-bit LSB-first bit gatherer
// Appends up to 8 bits at position fill; pops the low 32 bits once fill>=32.
module block_packer_bit_accumulator
  import block_packer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        append,
  input  logic [7:0]  data,
  input  width_t      width,
  input  logic        pop,
  output logic [31:0] word,
  output logic        word_avail,
  output logic        can_append
);
  logic [39:0] buf_q;
  logic [5:0]  fill_q;
  logic [39:0] base;
  logic [5:0]  base_fill;
  logic [7:0]  mask;
  logic [39:0] ins;

  // A pop and an append may share a cycle: the append lands after the shift.
  always_comb begin
    base      = pop ? {32'h0, buf_q[39:32]} : buf_q;
    base_fill = pop ? fill_q - 6'd32 : fill_q;
    mask      = 8'((9'd1 << width) - 9'd1);
    ins       = 40'(data & mask) << base_fill;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= append ? (base | ins) : base;
      fill_q <= base_fill + (append ? 6'(width) : 6'd0);
    end
  end

  assign word       = buf_q[31:0];
  assign word_avail = (fill_q >= 6'd32);
  assign can_append = (fill_q <= 6'd32);
endmodule

// File: rtl/block_packer.sv
// rtl/block_packer.sv - serialises one header+residual block into 32-bit words
// Two header words, then residuals packed at their channel widths, LSB-first.
module block_packer
  import block_packer_pkg::*;
(
  input logic           clk,
  input logic           rst,
  block_packer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR0 = 2'd1;
  localparam logic [1:0] HDR1 = 2'd2;
  localparam logic [1:0] BODY = 2'd3;
  localparam int NUM_ELEMS = NUM_PIXELS * NUM_CH;

  logic [1:0]         state;
  header_residual_reg hr_q;
  logic [7:0]         elem_cnt;
  logic [5:0]         words_left;
  logic               out_valid_q;
  logic               out_last_q;
  logic [WORD_W-1:0]  out_data_q;

  width_t            cw [NUM_CH];
  logic [5:0]        total_w;
  logic [4:0]        pix;
  logic [1:0]        ch;
  logic              accept, hs, out_free, body_load, append;
  logic              can_append, word_avail;
  logic [WORD_W-1:0] acc_word;

  always_comb begin
    cw[0]     = clamp_width(hr_q.header.widths.r_w);
    cw[1]     = clamp_width(hr_q.header.widths.g_w);
    cw[2]     = clamp_width(hr_q.header.widths.b_w);
    cw[3]     = clamp_width(hr_q.header.widths.a_w);
    total_w   = 6'(cw[0]) + 6'(cw[1]) + 6'(cw[2]) + 6'(cw[3]);
    pix       = elem_cnt[6:2];
    ch        = elem_cnt[1:0];
    accept    = bus.in_valid && bus.in_ready;
    hs        = out_valid_q && bus.out_ready;
    out_free  = !out_valid_q || bus.out_ready;
    // Body words start streaming on the same edge the second header word leaves.
    body_load = word_avail && (words_left != 6'd0) &&
                ((state == HDR1 && hs) || (state == BODY && out_free));
    append    = (state != IDLE) && (elem_cnt < 8'(NUM_ELEMS)) &&
                (can_append || body_load);
  end

  block_packer_bit_accumulator u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .append     (append),
    .data       (hr_q.residuals[pix][ch]),
    .width      (cw[ch]),
    .pop        (body_load),
    .word       (acc_word),
    .word_avail (word_avail),
    .can_append (can_append)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hr_q        <= '0;
      elem_cnt    <= '0;
      words_left  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (append) elem_cnt <= elem_cnt + 8'd1;
      if (body_load) begin
        out_data_q  <= acc_word;
        out_valid_q <= 1'b1;
        out_last_q  <= (words_left == 6'd1);
        words_left  <= words_left - 6'd1;
      end
      case (state)
        IDLE: if (accept) begin
          hr_q        <= bus.hr_reg;
          elem_cnt    <= '0;
          out_data_q  <= bus.hr_reg.header.min_values;
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
          state       <= HDR0;
        end
        HDR0: if (hs) begin
          out_data_q <= {16'h0, cw[0], cw[1], cw[2], cw[3]};
          out_last_q <= (total_w == 6'd0);
          words_left <= total_w;
          state      <= HDR1;
        end
        HDR1: if (hs) begin
          if (!body_load) out_valid_q <= 1'b0;
          if (out_last_q) out_last_q <= 1'b0;
          state <= out_last_q ? IDLE : BODY;
        end
        BODY: if (hs && !body_load) begin
          out_valid_q <= 1'b0;
          if (out_last_q) begin
            out_last_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !rst && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_block_packer.sv
// tb/tb_block_packer.sv - randomized self-checking bench for block_packer
// Expected words come from a bit-queue model built straight from the block contents.
module tb_block_packer;
  import block_packer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd_ready = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   done_cyc = 0;
  logic [32:0] mdl_q [$];
  logic [32:0] exp_q [$];
  logic [32:0] got_q [$];
  logic [32:0] e;
  logic [32:0] prev_word;
  logic        stall_prev = 1'b0;

  block_packer_if bus();

  block_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: gather every element's low bits into one bit queue, cut into words.
  task automatic build_model(input header_residual_reg h);
    logic  bits [$];
    int    w [4];
    int    tot;
    logic [31:0] word;
    logic [32:0] last_e;
    w[0] = (h.header.widths.r_w > 8) ? 8 : int'(h.header.widths.r_w);
    w[1] = (h.header.widths.g_w > 8) ? 8 : int'(h.header.widths.g_w);
    w[2] = (h.header.widths.b_w > 8) ? 8 : int'(h.header.widths.b_w);
    w[3] = (h.header.widths.a_w > 8) ? 8 : int'(h.header.widths.a_w);
    tot = w[0] + w[1] + w[2] + w[3];
    mdl_q.delete();
    mdl_q.push_back({1'b0, h.header.min_values.r_min, h.header.min_values.g_min,
                     h.header.min_values.b_min, h.header.min_values.a_min});
    mdl_q.push_back({1'b0, 16'h0, 4'(w[0]), 4'(w[1]), 4'(w[2]), 4'(w[3])});
    for (int p = 0; p < NUM_PIXELS; p++)
      for (int c = 0; c < NUM_CH; c++)
        for (int b = 0; b < w[c]; b++)
          bits.push_back(h.residuals[p][c][b]);
    while (bits.size() >= 32) begin
      for (int i = 0; i < 32; i++) word[i] = bits.pop_front();
      mdl_q.push_back({1'b0, word});
    end
    if (tot * 32 != 0 || bits.size() == 0) begin
      last_e = mdl_q.pop_back();
      last_e[32] = 1'b1;
      mdl_q.push_back(last_e);
    end
  endtask

  function automatic header_residual_reg mk_block(input logic [31:0] mins,
                                                  input logic [15:0] ws, input int kind);
    header_residual_reg h;
    h.header.min_values = mins;
    h.header.widths     = ws;
    for (int p = 0; p < NUM_PIXELS; p++)
      for (int c = 0; c < NUM_CH; c++)
        case (kind)
          1:       h.residuals[p][c] = 8'(p);
          2:       h.residuals[p][c] = (c == 0) ? 8'(p & 1) : 8'($urandom);
          3:       h.residuals[p][c] = 8'hFF;
          default: h.residuals[p][c] = 8'($urandom);
        endcase
    return h;
  endfunction

  task automatic send_block(input header_residual_reg h);
    int t = 0;
    build_model(h);
    @(posedge clk); #1;
    bus.hr_reg   = h;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    chk("accept_timeout", (t < 1000), 1);
    accept_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.hr_reg   = '0;
    got_q.delete();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    @(negedge clk);
    chk("first_word_latency", bus.out_valid, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      t++;
      @(negedge clk);
    end
    chk("block_done_timeout", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_word", {bus.out_last, bus.out_data}, prev_word);
      end
      if (exp_q.size() != 0) chk("in_ready_busy", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word got %h expected no word", {bus.out_last, bus.out_data});
        end else begin
          e = exp_q.pop_front();
          chk("word", {bus.out_last, bus.out_data}, e);
          got_q.push_back({bus.out_last, bus.out_data});
          if (bus.out_last) done_cyc = cyc + 1;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
    end
  end

  initial begin
    header_residual_reg h;
    int t;
    bus.in_valid = 1'b0;
    bus.hr_reg   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    h = mk_block(32'h01020304, 16'h0000, 0);
    send_block(h);
    chk("c1_len", mdl_q.size(), 2);
    chk("c1_w0", mdl_q[0], {1'b0, 32'h01020304});
    chk("c1_w1", mdl_q[1], {1'b1, 32'h00000000});
    wait_done();

    h = mk_block($urandom, 16'h8888, 1);
    send_block(h);
    chk("c2_len", mdl_q.size(), 34);
    chk("c2_w2", mdl_q[2], {1'b0, 32'h00000000});
    chk("c2_w3", mdl_q[3], {1'b0, 32'h01010101});
    chk("c2_w33", mdl_q[33], {1'b1, 32'h1F1F1F1F});
    wait_done();
    chk("c2_cycles_le_132", ((done_cyc - accept_cyc) <= 132), 1);

    h = mk_block($urandom, 16'h1000, 2);
    send_block(h);
    chk("c3_len", mdl_q.size(), 3);
    chk("c3_w2", mdl_q[2], {1'b1, 32'hAAAAAAAA});
    wait_done();

    h = mk_block($urandom, 16'h3200, 3);
    send_block(h);
    chk("c4_len", mdl_q.size(), 7);
    for (int i = 2; i < 7; i++) chk("c4_body", mdl_q[i][31:0], 32'hFFFFFFFF);
    wait_done();

    rnd_ready = 1'b1;
    h = mk_block($urandom, 16'h8888, 1);
    send_block(h);
    wait_done();
    chk("c5_words", got_q.size(), 34);

    rnd_ready = 1'b0;
    h = mk_block($urandom, 16'h8888, 1);
    send_block(h);
    t = 0;
    while (got_q.size() < 6 && t < 500) begin
      t++;
      @(negedge clk);
    end
    chk("c6_reach_word5", (got_q.size() >= 6), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("c6_rst_out_valid", bus.out_valid, 0);
    chk("c6_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("c6_release_in_ready", bus.in_ready, 1);
    h = mk_block(32'h01020304, 16'h0000, 0);
    send_block(h);
    wait_done();
    chk("c6_after_len", got_q.size(), 2);

    rnd_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      h = mk_block($urandom,
                   {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)),
                    4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))}, 0);
      send_block(h);
    end
    wait_done();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
